cdc_in_arbiter: RTL and testbench
=================================

Name: cdc_in_arbiter

Overview:
Round-robin burst arbiter in the clk1 domain that shares the single CDC input port (in_valid/in_account/in_A/in_T, back-pressured by ready) between NREQ requesters. A winner holds the port for up to BURST accepted words, then the grant rotates. Output is a registered holding stage, so the CDC sees stable data until it is accepted.

Parameters:
DSIZE, 8, word width of account/A/T fields
NREQ, 2, number of requesters (2..8)
BURST, 5, max words per grant (>=1)

Ports:
clk1  in  1  single clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester word valid
req_ready  out  NREQ  per-requester accept (combinational)
req_account  in  NREQ*DSIZE  packed, requester i at [i*DSIZE +: DSIZE]
req_A  in  NREQ*DSIZE  packed, same layout
req_T  in  NREQ*DSIZE  packed, same layout
ready  in  1  CDC can accept a word this cycle
in_valid  out  1  registered word valid to CDC
in_account  out  DSIZE  registered
in_A  out  DSIZE  registered
in_T  out  DSIZE  registered
grant  out  NREQ  one-hot current owner, 0 in IDLE
burst_done  out  1  one-cycle pulse when a grant is released

Behaviour:
- Reset (rst_n=0 at posedge clk1): state=IDLE, in_valid=0, in_account/in_A/in_T=0, grant=0, burst_done=0, cnt=0, last_ptr=NREQ-1 (requester 0 wins first). Reset mid-burst drops the held word; no CDC transfer is completed.
- Output transfer to CDC: a word transfers on any cycle with in_valid=1 && ready=1.
- Output stage is free when in_valid=0 || ready=1.
- States: IDLE, BUSY.
- IDLE:
  - req_ready=0.
  - If any req_valid: winner = first i with req_valid[i], scanning from (last_ptr+1) mod NREQ upward, with wrap-around.
  - Next cycle: BUSY, grant=onehot(winner), cnt=0, last_ptr=winner.
  - Arbitration costs exactly 1 cycle.
- BUSY, owner g:
  - req_ready[g] = stage free.
  - All other req_ready bits = 0.
  - Accept occurs when req_valid[g] && req_ready[g].
  - On accept: load in_account/in_A/in_T from slice g, set in_valid=1, cnt=cnt+1.
  - Accept-to-in_valid latency is 1 cycle.
  - Stage free and no accept: in_valid=0 if the held word transferred; otherwise the held word is kept.
  - With ready stuck high, one word per cycle is sustained.
- Release conditions (evaluated each BUSY cycle):
  - (a) Accept that brings cnt to BURST.
  - (b) Stage free && req_valid[g]=0 (owner went idle).
  - On release: next state IDLE, grant=0, burst_done=1 for one cycle, cnt=0.
  - A held word still pending in the output register continues to drain in IDLE; a new owner's first accept waits for the stage to be free.
- Simultaneous events:
  - Accept on the BURST-th word plus owner dropping valid: a single release, a single burst_done pulse.
  - ready low while the owner is valid: no release; the grant is held indefinitely.
- Data stability: while in_valid=1 && ready=0, the in_* outputs must not change.
- cnt width: clog2(BURST+1). last_ptr width: clog2(NREQ). Wrap of last_ptr is modulo NREQ.
- Non-owners are never accepted. Requester data is sampled only on accept.

Test Plan:
- Reset, single requester: req0 sends accounts 10,11,12 with ready=1 -> in_valid 3 consecutive cycles starting 2 cycles after req_valid rises (1 arbitration + 1 register); then burst_done pulses and grant returns to 0.
- Burst limit, BURST=5: req0 streams 7 words (1..7) -> words 1-5 transfer, burst_done; re-arbitration grants req0 again, and words 6-7 follow after exactly one idle arbitration cycle.
- Fairness: both requesters are continuously valid (req0 100.., req1 200..) -> CDC order is 100-104, 200-204, 105-109; grant alternates 01,10,01.
- Back-pressure: ready=0 for 4 cycles while holding account 42 -> in_valid=1 and in_account=42 stay stable; req_ready[g]=0; no cnt advance; transfer on the first ready=1 cycle.
- Simultaneous release: the 5th accept coincides with req_valid[g] falling -> exactly one burst_done pulse and a single return to IDLE.
- Mid-burst reset: assert rst_n=0 for 1 cycle after the 2nd word -> all outputs 0 next cycle; after release, req0 wins first even if req1 also requests.

Source files
------------

// File: rtl/cdc_in_arbiter.sv
// cdc_in_arbiter: round-robin burst arbiter sharing the single CDC input port
// among NREQ requesters. An owner keeps the port for up to BURST accepted
// words. The output is a registered holding stage that stays stable until
// the CDC accepts it.
module cdc_in_arbiter #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NREQ  = 2,
    parameter int unsigned BURST = 5
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*DSIZE-1:0]   req_account,
    input  logic [NREQ*DSIZE-1:0]   req_A,
    input  logic [NREQ*DSIZE-1:0]   req_T,
    input  logic                    ready,
    output logic                    in_valid,
    output logic [DSIZE-1:0]        in_account,
    output logic [DSIZE-1:0]        in_A,
    output logic [DSIZE-1:0]        in_T,
    output logic [NREQ-1:0]         grant,
    output logic                    burst_done
);

    localparam int unsigned CNT_W = $clog2(BURST + 1);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic               in_valid_q, in_valid_d;
    logic [DSIZE-1:0]   acc_q, acc_d;
    logic [DSIZE-1:0]   a_q, a_d;
    logic [DSIZE-1:0]   t_q, t_d;
    logic               burst_done_q, burst_done_d;

    logic               own_valid;
    logic [DSIZE-1:0]   own_acc, own_a, own_t;
    logic [NREQ-1:0]    rot_valid;
    int unsigned        win_off;
    logic [PTR_W-1:0]   win_idx;
    logic               stage_free;
    logic               accept;

    // Select the current owner's valid and payload (owner index == last_ptr)
    always_comb begin
        own_valid = 1'b0;
        own_acc   = '0;
        own_a     = '0;
        own_t     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (last_ptr_q == PTR_W'(i)) begin
                own_valid = req_valid[i];
                own_acc   = req_account[i*DSIZE +: DSIZE];
                own_a     = req_A[i*DSIZE +: DSIZE];
                own_t     = req_T[i*DSIZE +: DSIZE];
            end
        end
    end

    // Round-robin pick: rotate valids so the slot after last_ptr sits at bit 0
    always_comb begin
        rot_valid = NREQ'({req_valid, req_valid} >> (32'(last_ptr_q) + 32'd1));
        win_off   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                win_off = unsigned'(k);
            end
        end
        win_idx = PTR_W'((32'(last_ptr_q) + 32'd1 + win_off) % NREQ);
    end

    assign stage_free = !in_valid_q || ready;
    assign accept     = (state_q == BUSY) && own_valid && stage_free;

    // Only the owner sees ready, and only while the holding stage can take a word
    always_comb begin
        req_ready = '0;
        if (state_q == BUSY && stage_free) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_ptr_q == PTR_W'(i)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Next-state: arbitration, burst counting/release and holding-stage update
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        last_ptr_d   = last_ptr_q;
        in_valid_d   = in_valid_q;
        acc_d        = acc_q;
        a_d          = a_q;
        t_d          = t_q;
        burst_done_d = 1'b0;

        if (accept) begin
            in_valid_d = 1'b1;
            acc_d      = own_acc;
            a_d        = own_a;
            t_d        = own_t;
        end else if (ready) begin
            in_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d    = BUSY;
                    grant_d    = NREQ'(1) << win_idx;
                    cnt_d      = '0;
                    last_ptr_d = win_idx;
                end
            end
            BUSY: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((accept && cnt_q == CNT_W'(BURST - 1)) || (stage_free && !own_valid)) begin
                    state_d      = IDLE;
                    grant_d      = '0;
                    cnt_d        = '0;
                    burst_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            cnt_q        <= '0;
            last_ptr_q   <= PTR_W'(NREQ - 1);
            in_valid_q   <= 1'b0;
            acc_q        <= '0;
            a_q          <= '0;
            t_q          <= '0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            last_ptr_q   <= last_ptr_d;
            in_valid_q   <= in_valid_d;
            acc_q        <= acc_d;
            a_q          <= a_d;
            t_q          <= t_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign in_valid   = in_valid_q;
    assign in_account = acc_q;
    assign in_A       = a_q;
    assign in_T       = t_q;
    assign grant      = grant_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Testbench for cdc_in_arbiter: directed scenarios plus random traffic, every
// cycle compared against a transaction-level reference model.
module tb_cdc_in_arbiter;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned NREQ  = 2;
    localparam int unsigned BURST = 5;

    logic                  clk1 = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DSIZE-1:0] req_account;
    logic [NREQ*DSIZE-1:0] req_A;
    logic [NREQ*DSIZE-1:0] req_T;
    logic                  ready;
    logic                  in_valid;
    logic [DSIZE-1:0]      in_account;
    logic [DSIZE-1:0]      in_A;
    logic [DSIZE-1:0]      in_T;
    logic [NREQ-1:0]       grant;
    logic                  burst_done;

    always #5 clk1 = ~clk1;

    cdc_in_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_account (req_account),
        .req_A       (req_A),
        .req_T       (req_T),
        .ready       (ready),
        .in_valid    (in_valid),
        .in_account  (in_account),
        .in_A        (in_A),
        .in_T        (in_T),
        .grant       (grant),
        .burst_done  (burst_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner (-1 = nobody), round-robin memory, words this grant,
    // and the single word waiting for the CDC.
    int         m_owner;
    int         m_last;
    int         m_cnt;
    bit         m_hv;
    logic [7:0] m_acc, m_a, m_t;
    bit         m_done;

    logic [7:0] wq0[$];
    logic [7:0] wq1[$];
    logic [7:0] dut_log[$];
    int         vld_pct;
    int         n_done;
    int         cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] f_a(input logic [7:0] w);
        return w ^ 8'hA5;
    endfunction

    function automatic logic [7:0] f_t(input logic [7:0] w);
        return w + 8'd3;
    endfunction

    // Present queue heads (randomly gated) and junk data when not valid
    task automatic drive_reqs();
        logic [7:0] w0, w1;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        req_valid = '0;
        if (wq0.size() > 0 && $urandom_range(99) < vld_pct) begin
            req_valid[0] = 1'b1;
            w0 = wq0[0];
        end
        if (wq1.size() > 0 && $urandom_range(99) < vld_pct) begin
            req_valid[1] = 1'b1;
            w1 = wq1[0];
        end
        req_account = {w1, w0};
        req_A       = {f_a(w1), f_a(w0)};
        req_T       = {f_t(w1), f_t(w0)};
    endtask

    task automatic model_update();
        bit free;
        bit acc;
        int g;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_cnt   = 0;
            m_hv    = 0;
            m_acc   = '0;
            m_a     = '0;
            m_t     = '0;
            m_done  = 0;
            return;
        end
        free   = !m_hv || ready;
        m_done = 0;
        if (m_owner < 0) begin
            if (req_valid != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i = (m_last + k) % NREQ;
                    if (req_valid[i]) begin
                        m_owner = i;
                        break;
                    end
                end
                m_last = m_owner;
                m_cnt  = 0;
            end
            if (m_hv && ready) m_hv = 0;
        end else begin
            g   = m_owner;
            acc = req_valid[g] && free;
            if (acc) begin
                m_hv  = 1;
                m_acc = req_account[g*DSIZE +: DSIZE];
                m_a   = req_A[g*DSIZE +: DSIZE];
                m_t   = req_T[g*DSIZE +: DSIZE];
                m_cnt++;
            end else if (m_hv && ready) begin
                m_hv = 0;
            end
            if ((acc && m_cnt == BURST) || (free && !req_valid[g])) begin
                m_owner = -1;
                m_cnt   = 0;
                m_done  = 1;
            end
        end
    endtask

    // One clock: drive at negedge, check req_ready before the edge, outputs after
    task automatic tick();
        logic [1:0] exp_rr;
        logic [1:0] exp_gnt;
        logic [1:0] acc_bits;
        drive_reqs();
        #1;
        exp_rr = (m_owner >= 0 && (!m_hv || ready)) ? 2'(1 << m_owner) : 2'b00;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rr));
        acc_bits = req_valid & req_ready;
        if (rst_n && in_valid && ready) dut_log.push_back(in_account);
        model_update();
        @(posedge clk1);
        cyc++;
        if (rst_n) begin
            if (acc_bits[0]) void'(wq0.pop_front());
            if (acc_bits[1]) void'(wq1.pop_front());
        end
        @(negedge clk1);
        exp_gnt = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        check_eq("in_valid",   32'(in_valid),   32'(m_hv));
        check_eq("in_account", 32'(in_account), 32'(m_acc));
        check_eq("in_A",       32'(in_A),       32'(m_a));
        check_eq("in_T",       32'(in_T),       32'(m_t));
        check_eq("grant",      32'(grant),      32'(exp_gnt));
        check_eq("burst_done", 32'(burst_done), 32'(m_done));
        if (burst_done) n_done++;
    endtask

    task automatic run_for(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wq0.delete();
        wq1.delete();
        tick();
        rst_n = 1'b1;
        dut_log.delete();
        n_done = 0;
    endtask

    task automatic check_log(input string tag, input int idx, input int exp);
        if (idx < dut_log.size()) check_eq(tag, 32'(dut_log[idx]), 32'(exp));
        else check_eq({tag, "_missing"}, 32'(dut_log.size()), 32'(idx + 1));
    endtask

    initial begin
        int t_rise;
        int first_iv;
        int budget;
        int exp_w;

        rst_n       = 1'b0;
        ready       = 1'b0;
        req_valid   = '0;
        req_account = '0;
        req_A       = '0;
        req_T       = '0;
        vld_pct     = 100;
        n_done      = 0;
        cyc         = 0;
        m_owner     = -1;
        m_last      = NREQ - 1;
        m_cnt       = 0;
        m_hv        = 0;
        m_acc       = '0;
        m_a         = '0;
        m_t         = '0;
        m_done      = 0;
        @(posedge clk1);
        @(negedge clk1);

        // Reset, single requester: 10,11,12 with two-cycle latency
        do_reset();
        ready = 1'b1;
        for (int w = 10; w <= 12; w++) wq0.push_back(8'(w));
        t_rise   = cyc;
        first_iv = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (in_valid && first_iv < 0) first_iv = cyc;
        end
        check_eq("single_latency", 32'(first_iv - t_rise), 32'd2);
        for (int i = 0; i < 3; i++) check_log("single_word", i, 10 + i);
        check_eq("single_done_cnt", 32'(n_done), 32'd1);

        // Burst limit: 7 words split 5 + 2 with one re-arbitration
        do_reset();
        ready = 1'b1;
        for (int w = 1; w <= 7; w++) wq0.push_back(8'(w));
        run_for(20);
        for (int i = 0; i < 7; i++) check_log("burst_word", i, 1 + i);
        check_eq("burst_done_cnt", 32'(n_done), 32'd2);

        // Fairness: alternating bursts of five
        do_reset();
        ready = 1'b1;
        for (int w = 0; w < 15; w++) begin
            wq0.push_back(8'(100 + w));
            wq1.push_back(8'(200 + w));
        end
        run_for(25);
        for (int i = 0; i < 15; i++) begin
            exp_w = ((i / 5) == 1 ? 200 : 100) + ((i / 5) == 2 ? 5 : 0) + (i % 5);
            check_log("fair_order", i, exp_w);
        end

        // Back-pressure: word 42 held stable for 4 cycles
        do_reset();
        ready = 1'b0;
        wq0.push_back(8'd42);
        wq0.push_back(8'd43);
        run_for(2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("bp_hold_valid", 32'(in_valid), 32'd1);
            check_eq("bp_hold_acc", 32'(in_account), 32'd42);
        end
        ready = 1'b1;
        tick();
        check_eq("bp_first_xfer", 32'(dut_log.size()), 32'd1);
        run_for(6);
        check_log("bp_word", 0, 42);
        check_log("bp_word", 1, 43);

        // Simultaneous release: 5th accept followed by owner going idle
        do_reset();
        ready = 1'b1;
        for (int w = 60; w < 65; w++) wq0.push_back(8'(w));
        run_for(12);
        check_eq("simul_done_cnt", 32'(n_done), 32'd1);
        check_eq("simul_words", 32'(dut_log.size()), 32'd5);

        // Mid-burst reset after the 2nd word, then req0 must win first again
        do_reset();
        ready = 1'b1;
        for (int w = 0; w < 10; w++) begin
            wq0.push_back(8'(30 + w));
            wq1.push_back(8'(70 + w));
        end
        budget = 0;
        while (dut_log.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        check_eq("mrst_reach_2", 32'(dut_log.size() >= 2), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("mrst_in_valid", 32'(in_valid), 32'd0);
        check_eq("mrst_grant", 32'(grant), 32'd0);
        rst_n = 1'b1;
        budget = 0;
        while (grant == '0 && budget < 5) begin
            tick();
            budget++;
        end
        check_eq("mrst_first_winner", 32'(grant), 32'd1);

        // Random traffic with random back-pressure and occasional reset
        do_reset();
        vld_pct = 75;
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(99) < 70);
            rst_n = ($urandom_range(999) != 0);
            if (wq0.size() == 0 && $urandom_range(15) == 0) begin
                for (int k = 0; k < int'($urandom_range(12, 1)); k++) wq0.push_back(8'($urandom));
            end
            if (wq1.size() == 0 && $urandom_range(15) == 0) begin
                for (int k = 0; k < int'($urandom_range(12, 1)); k++) wq1.push_back(8'($urandom));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
